sprite_line_mixer: RTL and testbench

Parametrised successor to the fixed 9-lane pixel shifter and priority encoder pair in the PPU datapath. Holds NUM_SPRITES sprite channels plus one double-buffered background channel. Each sprite channel has its own X countdown, horizontal flip and behind-background flag. On every pixel_en it shifts all lanes, resolves priority and emits one registered pixel (colour index + palette select) to the palette lookup. It also tracks sprite-0 collision and background underrun.

---
 rtl/sprite_line_mixer.sv | 198 +++++++++++++++++++
 tb/tb_sprite_line_mixer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sprite_line_mixer.sv
// sprite_line_mixer: per-pixel sprite/background lane shifter with priority resolve,
// sprite-0 collision and background underrun tracking.
module sprite_line_mixer #(
   parameter int NUM_SPRITES = 8,
   parameter int BPP = 2,
   parameter int TILE_W = 16,
   parameter int PAL_W = 3,
   parameter int X_W = 11,
   parameter int CW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
   parameter int FX_W = $clog2(TILE_W)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  line_start,
   input  logic [FX_W-1:0]       fine_x,
   input  logic                  spr_load,
   input  logic [CW-1:0]         spr_chan,
   input  logic [TILE_W*BPP-1:0] spr_pattern,
   input  logic [X_W-1:0]        spr_x,
   input  logic [PAL_W-1:0]      spr_palette,
   input  logic                  spr_behind,
   input  logic                  spr_hflip,
   input  logic                  spr_clear_all,
   input  logic                  bg_load,
   input  logic [TILE_W*BPP-1:0] bg_pattern,
   input  logic [PAL_W-1:0]      bg_palette,
   output logic                  bg_pending_full,
   input  logic                  pixel_en,
   output logic                  pix_valid,
   output logic [BPP-1:0]        pix_index,
   output logic [PAL_W-1:0]      pix_palette,
   output logic                  pix_is_sprite,
   output logic [CW-1:0]         pix_chan,
   input  logic                  hit_clear,
   output logic                  sprite0_hit,
   output logic                  bg_underrun
);
   localparam int PW = TILE_W * BPP;
   localparam int RW = $clog2(TILE_W + 1);

   typedef enum logic {ST_RUN, ST_SKIP} state_t;
   state_t state, state_nx;
   logic [FX_W-1:0] skip_cnt, skip_nx;

   logic             spr_act  [NUM_SPRITES];
   logic [X_W-1:0]   spr_xcnt [NUM_SPRITES];
   logic [RW-1:0]    spr_rem  [NUM_SPRITES];
   logic [PW-1:0]    spr_sh   [NUM_SPRITES];
   logic [PAL_W-1:0] spr_pal  [NUM_SPRITES];
   logic             spr_beh  [NUM_SPRITES];
   logic [BPP-1:0]   lane_pix [NUM_SPRITES];
   logic [PW-1:0]    spr_rev;

   logic [PW-1:0]    bg_sh, bg_pend;
   logic [RW-1:0]    bg_rem;
   logic [PAL_W-1:0] bg_pal, bg_pend_pal, bg_pal_cur;
   logic [BPP-1:0]   bg_pix, win_pix;
   logic [PAL_W-1:0] win_pal;
   logic [CW-1:0]    win_chan;
   logic             win_found, win_beh, sprite_win, step, fire;

   assign step = pixel_en && !line_start;
   assign fire = step && state == ST_RUN;
   assign bg_pix = bg_rem != '0 ? bg_sh[BPP-1:0] : bg_pending_full ? bg_pend[BPP-1:0] : '0;
   assign bg_pal_cur = bg_rem != '0 ? bg_pal : bg_pend_pal;
   assign sprite_win = win_found && !(win_beh && bg_pix != '0);

   always_comb begin
      state_nx = state;
      skip_nx = skip_cnt;
      if (line_start) begin
         skip_nx = fine_x;
         state_nx = fine_x != '0 ? ST_SKIP : ST_RUN;
      end else if (pixel_en && state == ST_SKIP) begin
         skip_nx = skip_cnt - 1'b1;
         state_nx = skip_cnt == FX_W'(1) ? ST_RUN : ST_SKIP;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
         skip_cnt <= '0;
      end else begin
         state <= state_nx;
         skip_cnt <= skip_nx;
      end
   end

   // Walking from the highest lane down lets the lowest non-zero lane win.
   always_comb begin
      spr_rev = '0;
      win_found = 1'b0;
      win_beh = 1'b0;
      win_pix = '0;
      win_pal = '0;
      win_chan = '0;
      for (int k = 0; k < TILE_W; k++)
         spr_rev[k*BPP +: BPP] = spr_hflip ? spr_pattern[(TILE_W-1-k)*BPP +: BPP] : spr_pattern[k*BPP +: BPP];
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         lane_pix[i] = (spr_act[i] && spr_xcnt[i] == '0) ? spr_sh[i][BPP-1:0] : '0;
         if (lane_pix[i] != '0) begin
            win_found = 1'b1;
            win_beh = spr_beh[i];
            win_pix = lane_pix[i];
            win_pal = spr_pal[i];
            win_chan = CW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (reset) begin
            spr_act[i] <= 1'b0;
            spr_xcnt[i] <= '0;
            spr_rem[i] <= '0;
            spr_sh[i] <= '0;
            spr_pal[i] <= '0;
            spr_beh[i] <= 1'b0;
         end else if (spr_clear_all) begin
            spr_act[i] <= 1'b0;
         end else if (spr_load && spr_chan == CW'(i)) begin
            spr_act[i] <= 1'b1;
            spr_xcnt[i] <= spr_x;
            spr_rem[i] <= RW'(TILE_W);
            spr_sh[i] <= spr_rev;
            spr_pal[i] <= spr_palette;
            spr_beh[i] <= spr_behind;
         end else if (fire && spr_act[i]) begin
            if (spr_xcnt[i] != '0) spr_xcnt[i] <= spr_xcnt[i] - 1'b1;
            else begin
               spr_sh[i] <= spr_sh[i] >> BPP;
               spr_rem[i] <= spr_rem[i] - 1'b1;
               if (spr_rem[i] == RW'(1)) spr_act[i] <= 1'b0;
            end
         end
      end
   end

   // A pending load in the same cycle as a refill keeps the buffer full with the new row.
   always_ff @(posedge clk) begin
      if (reset) begin
         bg_sh <= '0;
         bg_rem <= '0;
         bg_pal <= '0;
         bg_pend <= '0;
         bg_pend_pal <= '0;
         bg_pending_full <= 1'b0;
         bg_underrun <= 1'b0;
      end else begin
         if (line_start) begin
            bg_underrun <= 1'b0;
            if (bg_pending_full) begin
               bg_sh <= bg_pend;
               bg_rem <= RW'(TILE_W);
               bg_pal <= bg_pend_pal;
               bg_pending_full <= 1'b0;
            end
         end else if (pixel_en) begin
            if (bg_rem != '0) begin
               bg_sh <= bg_sh >> BPP;
               bg_rem <= bg_rem - 1'b1;
            end else if (bg_pending_full) begin
               bg_sh <= bg_pend >> BPP;
               bg_rem <= RW'(TILE_W - 1);
               bg_pal <= bg_pend_pal;
               bg_pending_full <= 1'b0;
            end else bg_underrun <= 1'b1;
         end
         if (bg_load) begin
            bg_pend <= bg_pattern;
            bg_pend_pal <= bg_palette;
            bg_pending_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pix_valid <= 1'b0;
         pix_index <= '0;
         pix_palette <= '0;
         pix_is_sprite <= 1'b0;
         pix_chan <= '0;
         sprite0_hit <= 1'b0;
      end else begin
         pix_valid <= fire;
         if (fire) begin
            pix_index <= sprite_win ? win_pix : bg_pix;
            pix_palette <= sprite_win ? win_pal : bg_pal_cur;
            pix_is_sprite <= sprite_win;
            pix_chan <= sprite_win ? win_chan : '0;
         end
         sprite0_hit <= hit_clear ? 1'b0 : sprite0_hit || (fire && lane_pix[0] != '0 && bg_pix != '0);
      end
   end
endmodule

// File: tb/tb_sprite_line_mixer.sv
// tb_sprite_line_mixer: directed checks of priority, scrolling, collision and underrun.
module tb_sprite_line_mixer;
   logic        clk = 1'b0;
   logic        reset, line_start, spr_load, spr_behind, spr_hflip, spr_clear_all;
   logic        bg_load, pixel_en, hit_clear;
   logic [3:0]  fine_x;
   logic [2:0]  spr_chan, spr_palette, bg_palette;
   logic [31:0] spr_pattern, bg_pattern;
   logic [10:0] spr_x;
   logic        bg_pending_full, pix_valid, pix_is_sprite, sprite0_hit, bg_underrun;
   logic [1:0]  pix_index;
   logic [2:0]  pix_palette, pix_chan;
   int          errors = 0, checks = 0;

   sprite_line_mixer dut (
      .clk(clk), .reset(reset), .line_start(line_start), .fine_x(fine_x),
      .spr_load(spr_load), .spr_chan(spr_chan), .spr_pattern(spr_pattern), .spr_x(spr_x),
      .spr_palette(spr_palette), .spr_behind(spr_behind), .spr_hflip(spr_hflip),
      .spr_clear_all(spr_clear_all), .bg_load(bg_load), .bg_pattern(bg_pattern),
      .bg_palette(bg_palette), .bg_pending_full(bg_pending_full), .pixel_en(pixel_en),
      .pix_valid(pix_valid), .pix_index(pix_index), .pix_palette(pix_palette),
      .pix_is_sprite(pix_is_sprite), .pix_chan(pix_chan), .hit_clear(hit_clear),
      .sprite0_hit(sprite0_hit), .bg_underrun(bg_underrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] ep(input int s, input int ch, input int pal, input int idx);
      return {1'b1, 1'(s), 3'(ch), 3'(pal), 2'(idx)};
   endfunction

   task automatic px(input string tag, input logic [9:0] e);
      pixel_en = 1'b1;
      tick();
      pixel_en = 1'b0;
      chk(tag, {22'd0, pix_valid, pix_is_sprite, pix_chan, pix_palette, pix_index}, {22'd0, e});
   endtask

   task automatic load_spr(input int ch, input logic [31:0] pat, input int x, input int pal, input bit beh, input bit hf);
      spr_load = 1'b1; spr_chan = 3'(ch); spr_pattern = pat; spr_x = 11'(x);
      spr_palette = 3'(pal); spr_behind = beh; spr_hflip = hf;
      tick();
      spr_load = 1'b0; spr_behind = 1'b0; spr_hflip = 1'b0;
   endtask

   task automatic load_bg(input logic [31:0] pat, input int pal);
      bg_load = 1'b1; bg_pattern = pat; bg_palette = 3'(pal);
      tick();
      bg_load = 1'b0;
   endtask

   task automatic start_line(input int fx);
      line_start = 1'b1; fine_x = 4'(fx);
      tick();
      line_start = 1'b0; fine_x = '0;
   endtask

   task automatic clear_all();
      spr_clear_all = 1'b1;
      tick();
      spr_clear_all = 1'b0;
   endtask

   initial begin
      reset = 1'b1; line_start = 0; fine_x = 0; spr_load = 0; spr_chan = 0; spr_pattern = 0;
      spr_x = 0; spr_palette = 0; spr_behind = 0; spr_hflip = 0; spr_clear_all = 0;
      bg_load = 0; bg_pattern = 0; bg_palette = 0; pixel_en = 0; hit_clear = 0;
      tick(); tick();
      chk("reset", {pix_valid, pix_is_sprite, pix_chan, pix_palette, pix_index, bg_pending_full, sprite0_hit, bg_underrun}, 0);
      reset = 1'b0;

      for (int i = 0; i < 3; i++) px($sformatf("empty_%0d", i), ep(0, 0, 0, 0));
      chk("underrun_set", bg_underrun, 1);
      tick();
      chk("valid_drops", pix_valid, 0);

      load_bg(32'h0000_00E4, 2);
      chk("pend_full", bg_pending_full, 1);
      start_line(0);
      chk("pend_moved", {bg_pending_full, bg_underrun}, 0);
      for (int i = 0; i < 4; i++) px($sformatf("bg_seq_%0d", i), ep(0, 0, 2, i));

      load_spr(3, 32'h5555_5555, 2, 5, 0, 0);
      load_bg(32'h0, 1);
      start_line(0);
      load_bg(32'h0, 1);
      for (int i = 0; i < 19; i++)
         px($sformatf("spr3_%0d", i), (i >= 2 && i <= 17) ? ep(1, 3, 5, 1) : ep(0, 0, 1, 0));
      chk("no_underrun", bg_underrun, 0);

      load_spr(1, 32'hAAAA_AAAA, 0, 6, 0, 0);
      load_spr(4, 32'hAAAA_AAAA, 0, 7, 0, 0);
      px("low_chan_wins", ep(1, 1, 6, 2));
      load_spr(1, 32'hAAAA_AAAA, 0, 6, 1, 0);
      load_bg(32'hFFFF_FFFF, 4);
      start_line(0);
      px("behind_bg_wins", ep(0, 0, 4, 3));
      spr_load = 1'b1; spr_chan = 3'd2; spr_pattern = 32'h5555_5555; spr_x = 0; spr_palette = 3'd5;
      clear_all();
      spr_load = 1'b0;
      px("clear_beats_load", ep(0, 0, 4, 3));
      chk("no_hit_yet", sprite0_hit, 0);

      load_spr(0, 32'h5555_5555, 0, 3, 0, 0);
      px("spr0_over_bg", ep(1, 0, 3, 1));
      chk("hit_set", sprite0_hit, 1);
      hit_clear = 1'b1;
      px("spr0_clear_px", ep(1, 0, 3, 1));
      hit_clear = 1'b0;
      chk("hit_clear_wins", sprite0_hit, 0);

      clear_all();
      load_bg(32'h0, 1);
      start_line(0);
      load_spr(2, 32'h0000_0001, 0, 5, 0, 1);
      for (int i = 0; i < 16; i++)
         px($sformatf("hflip_%0d", i), (i == 15) ? ep(1, 2, 5, 1) : ep(0, 0, 1, 0));

      load_spr(5, 32'h0000_0006, 0, 7, 0, 0);
      load_bg(32'h0000_00E4, 2);
      start_line(3);
      for (int i = 0; i < 3; i++) begin
         pixel_en = 1'b1;
         tick();
         pixel_en = 1'b0;
         chk($sformatf("skip_%0d", i), pix_valid, 0);
      end
      px("after_skip_a", ep(1, 5, 7, 2));
      px("after_skip_b", ep(1, 5, 7, 1));
      px("after_skip_c", ep(0, 0, 2, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
